// File: rtl/pll_ctrl_pkg.sv
// Shared types and sizing helpers for the PLL lock sequencer.
package pll_ctrl_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    StIdle,
    StPrst,
    StWaitLock,
    StStable,
    StRun,
    StRetry,
    StFault
  } pll_state_e;

  // Width of the retry counter (MAX_RETRIES is limited to 1..15).
  localparam int unsigned RetryCntW = 4;

  // Largest of three cycle counts; sizes the shared down-counter.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return m;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous status bit, reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; the first may go metastable, the second settles it.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL power-up / recovery sequencer: pulses the PLL reset, qualifies LOCK as
// stable, then releases the downstream reset. Lock loss or timeout re-pulses
// the PLL a bounded number of times before latching a fault.
module pll_lock_sequencer
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 relock_req,
  input  logic                 pll_lock_async,
  output logic                 pll_rst,
  output logic                 dn_rst,
  output logic                 ready,
  output logic                 fault,
  output logic [RetryCntW-1:0] retry_cnt
);

  localparam int unsigned MaxCycles = max3(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES,
                                           LOCK_STABLE_CYCLES);
  localparam int unsigned CntW = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  // The counter counts down to zero inclusive, so a load of N-1 gives N cycles.
  localparam logic [CntW-1:0] RstLoad     = CntW'(RST_PULSE_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLoad = CntW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] StableLoad  = CntW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RetryCntW-1:0] MaxRetry = RetryCntW'(MAX_RETRIES);

  logic lock_s;

  pll_state_e           state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [RetryCntW-1:0] retry_q, retry_d;
  logic                 cnt_zero;

  logic pll_rst_q, pll_rst_d;
  logic dn_rst_q, dn_rst_d;
  logic ready_q, ready_d;
  logic fault_q, fault_d;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock_async),
    .q   (lock_s)
  );

  assign cnt_zero = (cnt_q == '0);

  // Next-state, counter and retry bookkeeping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;

    if (relock_req) begin
      state_d = StPrst;
      cnt_d   = RstLoad;
      retry_d = '0;
    end else if (!enable && (state_q != StFault)) begin
      // Standby keeps the retry history; a latched fault stays latched.
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StPrst;
          cnt_d   = RstLoad;
        end
        StPrst: begin
          if (cnt_zero) begin
            state_d = StWaitLock;
            cnt_d   = TimeoutLoad;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        StWaitLock: begin
          if (lock_s) begin
            state_d = StStable;
            cnt_d   = StableLoad;
          end else if (cnt_zero) begin
            state_d = StRetry;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        StStable: begin
          if (!lock_s) begin
            // A dropout restarts the wait without consuming a retry.
            state_d = StWaitLock;
            cnt_d   = TimeoutLoad;
          end else if (cnt_zero) begin
            state_d = StRun;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        StRun: begin
          if (!lock_s) begin
            state_d = StRetry;
          end
        end
        StRetry: begin
          if (retry_q == MaxRetry) begin
            state_d = StFault;
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = StPrst;
            cnt_d   = RstLoad;
          end
        end
        StFault: begin
          state_d = StFault;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // Output decode from the next state so the registered outputs track the state.
  always_comb begin
    pll_rst_d = (state_d == StIdle) || (state_d == StPrst) || (state_d == StFault);
    dn_rst_d  = (state_d != StRun);
    ready_d   = (state_d == StRun);
    fault_d   = (state_d == StFault);
  end

  // State, counter and retry registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pll_rst_q <= 1'b1;
      dn_rst_q  <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      pll_rst_q <= pll_rst_d;
      dn_rst_q  <= dn_rst_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign dn_rst    = dn_rst_q;
  assign ready     = ready_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer: a cycle-stepped vector table for the
// clean start and RUN lock loss, then hand sequences for timeout exhaustion,
// fault recovery, standby, lock chatter and synchronous reset.
module tb_pll_lock_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       relock_req;
  logic       pll_lock_async;
  logic       pll_rst;
  logic       dn_rst;
  logic       ready;
  logic       fault;
  logic [3:0] retry_cnt;

  int checks = 0;
  int errors = 0;

  // Observed output word: {pll_rst, dn_rst, ready, fault, retry_cnt}.
  logic [7:0] obs;
  assign obs = {pll_rst, dn_rst, ready, fault, retry_cnt};

  localparam logic [7:0] ORstR0  = 8'hC0;  // IDLE / PRST, retry 0
  localparam logic [7:0] OWaitR0 = 8'h40;  // WAIT_LOCK / STABLE / RETRY, retry 0
  localparam logic [7:0] ORun    = 8'h20;
  localparam logic [7:0] ORstR1  = 8'hC1;
  localparam logic [7:0] OWaitR1 = 8'h41;
  localparam logic [7:0] OFault3 = 8'hD3;

  always #5 clk = ~clk;

  pll_lock_sequencer #(
    .RST_PULSE_CYCLES    (4),
    .LOCK_TIMEOUT_CYCLES (32),
    .LOCK_STABLE_CYCLES  (8),
    .MAX_RETRIES         (3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .relock_req     (relock_req),
    .pll_lock_async (pll_lock_async),
    .pll_rst        (pll_rst),
    .dn_rst         (dn_rst),
    .ready          (ready),
    .fault          (fault),
    .retry_cnt      (retry_cnt)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic       rlk;
    logic       lock;
    int         ncyc;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock and sample at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Number of consecutive samples (including the current one) with pll_rst == lvl.
  task automatic count_while(input logic lvl, output int n);
    n = 0;
    while ((pll_rst === lvl) && (n < 200)) begin
      n++;
      step();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;

    // rst, en, rlk, lock, cycles, expected outputs after those cycles
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0,  2, ORstR0};   // reset values
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0,  3, ORstR0};   // standby in IDLE
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0,  1, ORstR0};   // PRST cycle 1
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0,  3, ORstR0};   // PRST cycle 4
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0,  1, OWaitR0};  // pll_rst falls
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 19, OWaitR0};  // 20th cycle of WAIT_LOCK
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 10, OWaitR0};  // 10 edges after LOCK rise
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1,  1, ORun};     // 11th edge: dn_rst falls
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0,  1, ORun};     // LOCK drop, sync stage 1
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0,  1, ORun};     // lock_s falls
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0,  1, OWaitR0};  // RETRY: ready 0, dn_rst 1
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0,  1, ORstR1};   // re-pulse, retry 1
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0,  3, ORstR1};   // PRST cycle 4
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1,  1, OWaitR1};  // WAIT_LOCK, LOCK rising
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b1,  9, OWaitR1};  // 10 edges after LOCK rise
    vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b1,  1, ORun};     // RUN clears retry_cnt

    rst            = 1'b1;
    enable         = 1'b0;
    relock_req     = 1'b0;
    pll_lock_async = 1'b0;

    for (int i = 0; i < 16; i++) begin
      rst            = vecs[i].rst;
      enable         = vecs[i].en;
      relock_req     = vecs[i].rlk;
      pll_lock_async = vecs[i].lock;
      repeat (vecs[i].ncyc) step();
      check($sformatf("vec%0d", i), obs, vecs[i].exp);
    end

    // Timeout exhaustion: relock from RUN with LOCK absent.
    pll_lock_async = 1'b0;
    relock_req     = 1'b1;
    step();
    relock_req = 1'b0;
    check("relock_from_run", obs, ORstR0);
    count_while(1'b1, n);
    check("prst_len", n, 4);
    for (int k = 1; k <= 3; k++) begin
      count_while(1'b0, n);
      check($sformatf("timeout_gap%0d", k), n, 33);
      check($sformatf("retry_cnt%0d", k), retry_cnt, k);
      count_while(1'b1, n);
      check($sformatf("repulse_len%0d", k), n, 4);
    end
    count_while(1'b0, n);
    check("timeout_gap4", n, 33);
    check("fault_entry", obs, OFault3);
    repeat (40) step();
    check("fault_sticky", obs, OFault3);

    // Fault recovery via relock_req, then standby request during STABLE.
    pll_lock_async = 1'b1;
    relock_req     = 1'b1;
    step();
    relock_req = 1'b0;
    check("fault_relock", obs, ORstR0);
    count_while(1'b1, n);
    check("relock_prst_len", n, 4);
    repeat (3) step();
    check("stable_before_disable", obs, OWaitR0);
    enable = 1'b0;
    step();
    check("stable_disable", obs, ORstR0);

    // Re-enable: one IDLE sample plus four PRST samples of pll_rst high.
    enable         = 1'b1;
    pll_lock_async = 1'b0;
    count_while(1'b1, n);
    check("reenable_rst_len", n, 5);

    // Lock chatter: high 5, low 1, high; stability count restarts.
    n = 0;
    pll_lock_async = 1'b1;
    repeat (5) begin
      step();
      n++;
    end
    pll_lock_async = 1'b0;
    step();
    n++;
    pll_lock_async = 1'b1;
    while ((dn_rst !== 1'b0) && (n < 100)) begin
      step();
      n++;
    end
    check("chatter_release_edges", n, 17);
    check("chatter_run", obs, ORun);

    // Lock loss in RUN, then synchronous reset while waiting for lock.
    pll_lock_async = 1'b0;
    count_while(1'b0, n);
    check("loss_to_prst", n, 4);
    check("loss_prst_state", obs, ORstR1);
    count_while(1'b1, n);
    check("loss_prst_len", n, 4);
    repeat (5) step();
    check("wait_retry1", obs, OWaitR1);
    rst = 1'b1;
    step();
    check("sync_rst", obs, ORstR0);
    rst = 1'b0;
    count_while(1'b1, n);
    check("restart_rst_len", n, 5);
    check("restart_wait", obs, OWaitR0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Power-up and recovery sequencer for the on-chip PLL wrapper (CLKI → CLKOS/CLKOS3). Runs on the PLL reference clock, pulses the PLL reset, waits for a stable LOCK, and only then releases the reset of logic clocked from CLKOS/CLKOS3. On lock loss or lock timeout it re-pulses the PLL reset up to a bounded number of retries, then latches a fault.

## Interface
- RST_PULSE_CYCLES, 16: PLL reset pulse width, in clk cycles (≥1).
- LOCK_TIMEOUT_CYCLES, 65536: maximum wait for LOCK after reset release (≥1).
- LOCK_STABLE_CYCLES, 1024: LOCK must stay high continuously this long before downstream reset release (≥1).
- MAX_RETRIES, 3: re-pulse attempts allowed before FAULT (1..15).

- clk  in  1  PLL reference clock (same net as CLKI); the only clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  level; 0 holds the PLL in reset (standby).
- relock_req  in  1  single-cycle pulse; forces a fresh sequence, clears retry count and fault.
- pll_lock_async  in  1  PLL LOCK, asynchronous to clk.
- pll_rst  out  1  active-high reset to the PLL.
- dn_rst  out  1  active-high reset for CLKOS/CLKOS3 domain logic (consumers re-synchronise it).
- ready  out  1  high only in RUN.
- fault  out  1  sticky; high only in FAULT.
- retry_cnt  out  4  re-pulses since last clean start, saturating at MAX_RETRIES.

## Operation
- pll_lock_async passes through a 2-FF synchronizer → lock_s; only lock_s is used.
- A single down-counter, width clog2 of the largest of the three cycle parameters, is loaded on each state entry.
- States:
  - IDLE: pll_rst=1, dn_rst=1. If enable=1 → PRST (counter=RST_PULSE_CYCLES).
  - PRST: pll_rst=1, dn_rst=1; at count 0 → WAIT_LOCK (counter=LOCK_TIMEOUT_CYCLES).
  - WAIT_LOCK: pll_rst=0, dn_rst=1. lock_s=1 → STABLE (counter=LOCK_STABLE_CYCLES). Timeout → RETRY.
  - STABLE: pll_rst=0, dn_rst=1. lock_s=0 → WAIT_LOCK (counter reloaded, no retry consumed). Count 0 → RUN.
  - RUN: pll_rst=0, dn_rst=0, ready=1. lock_s=0 → RETRY.
  - RETRY: one cycle; if retry_cnt==MAX_RETRIES → FAULT, else retry_cnt+1 and → PRST.
  - FAULT: pll_rst=1, dn_rst=1, fault=1; left only by relock_req or rst.
- Any state: enable=0 → IDLE (retry_cnt kept). relock_req=1 → PRST, retry_cnt=0; relock_req wins over every other condition in the same cycle except rst.
- retry_cnt cleared by rst, relock_req, and on each RUN entry from STABLE.
- All outputs are registered.

## Timing
- Reset values: pll_rst=1, dn_rst=1, ready=0, fault=0, retry_cnt=0, state IDLE, synchronizer flops 0.
- rst mid-sequence returns to IDLE on the next edge; outputs take reset values that edge.
- PRST lasts exactly RST_PULSE_CYCLES cycles of pll_rst=1 after IDLE.
- LOCK rising edge to lock_s: 2 cycles. lock_s rise to dn_rst fall: LOCK_STABLE_CYCLES+1 cycles.
- RUN lock loss: lock_s fall → ready=0, dn_rst=1 on the next edge (RETRY cycle), pll_rst=1 on the edge after.
- Glitch of LOCK shorter than one clk cycle may be missed; a glitch seen by lock_s in STABLE restarts the stability count.
- WAIT_LOCK timeout fires after exactly LOCK_TIMEOUT_CYCLES cycles without lock_s.

## Structure
- Package pll_ctrl_pkg: state enum (IDLE, PRST, WAIT_LOCK, STABLE, RUN, RETRY, FAULT), retry_cnt width constant.
- Sub-module sync_2ff (1-bit, reset to 0) for pll_lock_async; reused elsewhere for other async status inputs.

## Test plan
- Clean start: RST_PULSE=4, STABLE=8; enable=1, LOCK rises 20 cycles after pll_rst falls → pll_rst high 4 cycles, dn_rst falls 11 cycles after LOCK rise (2 sync + 8 stable + 1), ready=1, retry_cnt=0.
- Lock chatter: LOCK high 5 cycles, low 1, high → stability count restarts, dn_rst release delayed accordingly, retry_cnt stays 0.
- Timeout exhaustion: TIMEOUT=32, MAX_RETRIES=3, LOCK never rises → 3 re-pulses (retry_cnt 1,2,3), then fault=1, pll_rst=1 permanently.
- Lock loss in RUN: drop LOCK → ready=0/dn_rst=1 one cycle after lock_s falls, pll_rst pulse follows, relock → RUN with retry_cnt cleared to 0.
- Recovery controls: from FAULT pulse relock_req → PRST, fault=0, retry_cnt=0; enable=0 during STABLE → IDLE next edge, pll_rst=1.
- Sync reset mid-WAIT_LOCK: assert rst one cycle → all outputs at reset values next edge, sequence restarts from IDLE.
